// File: rtl/spi_rx_fifo_buffer_pkg.sv
// rtl/spi_rx_fifo_buffer_pkg.sv - register map, field positions and bus state type
package spi_rx_pkg;

  // Word offsets inside the register window
  localparam logic [7:0] OFF_STATUS = 8'h00;
  localparam logic [7:0] OFF_CTRL   = 8'h04;
  localparam logic [7:0] OFF_POP    = 8'h08;
  localparam logic [7:0] OFF_CLEAR  = 8'h0C;
  localparam logic [7:0] OFF_DATA   = 8'h10;

  // STATUS fields
  localparam int STATUS_NOT_EMPTY = 0;
  localparam int STATUS_FULL      = 1;
  localparam int STATUS_OVF       = 2;
  localparam int STATUS_COUNT_LSB = 8;

  // CTRL fields
  localparam int CTRL_IRQ_EN     = 0;
  localparam int CTRL_OVF_IRQ_EN = 1;
  localparam int CTRL_THR_LSB    = 8;

  // CLEAR command bits
  localparam int CLEAR_OVF   = 0;
  localparam int CLEAR_FLUSH = 1;

  // Bus slave: ACK drives mem_ready, HOLD waits for the master to drop a held request
  typedef enum logic [1:0] {
    BUS_IDLE,
    BUS_ACK,
    BUS_HOLD
  } bus_state_t;

endpackage

// File: rtl/spi_rx_fifo_buffer_if.sv
// rtl/spi_rx_fifo_buffer_if.sv - PicoRV32 native memory bus bundle
interface spi_rx_fifo_buffer_if;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;

  modport master (
    output mem_valid, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/spi_rx_fifo_buffer_core.sv
// rtl/spi_rx_fifo_buffer_core.sv - synchronous FIFO with push/pop/flush and head output
module rx_fifo_core #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  input  logic                       flush,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty,
  output logic                       overrun
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             pop_ok;
  logic             push_ok;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  // Flush beats everything; a pop on a full FIFO frees the slot for a same-cycle push
  assign pop_ok  = pop && !empty && !flush;
  assign push_ok = push && (!full || pop_ok) && !flush;
  assign overrun = push && !push_ok && !flush;

  assign head = mem[rd_ptr];

  // Block storage; readers gate on empty so no reset is needed
  always_ff @(posedge clk) begin
    if (resetn && push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (!resetn || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push_ok) - CW'(pop_ok);
    end
  end

endmodule

// File: rtl/spi_rx_fifo_buffer.sv
// rtl/spi_rx_fifo_buffer.sv - memory-mapped SPI receive FIFO with status, control and IRQ
module spi_rx_fifo_buffer
  import spi_rx_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
  parameter int          DATA_WORDS = 4,
  parameter int          DEPTH      = 4
) (
  input  logic                    clk,
  input  logic                    resetn,
  spi_rx_fifo_buffer_if.slave     bus,
  input  logic [32*DATA_WORDS-1:0] spi_rx_data,
  input  logic                    spi_rx_valid,
  output logic                    irq_rx
);
  localparam int CW        = $clog2(DEPTH) + 1;
  localparam int WIN_BYTES = 16 + 4 * DATA_WORDS;

  logic [31:0]              offset;
  logic                     in_window;
  logic [7:0]               word_off;
  logic                     is_write;
  bus_state_t               state;
  bus_state_t               state_next;
  logic                     accept;
  logic                     do_pop;
  logic                     do_clear;
  logic                     clr_ovf;
  logic                     flush;
  logic                     ctrl_wr;
  logic [32*DATA_WORDS-1:0] head;
  logic [CW-1:0]            count;
  logic [7:0]               count_ext;
  logic                     full;
  logic                     empty;
  logic                     overrun;
  logic                     irq_en;
  logic                     ovf_irq_en;
  logic [7:0]               threshold;
  logic                     overflow;
  logic [31:0]              rd_value;
  logic                     unused_bits;

  // Subtracting the base makes addresses below the window wrap to huge offsets
  assign offset    = bus.mem_addr - BASE_ADDR;
  assign in_window = (offset < 32'(WIN_BYTES));
  assign word_off  = {offset[7:2], 2'b00};
  assign is_write  = |bus.mem_wstrb;
  assign count_ext = 8'(count);

  assign unused_bits = ^{offset[1:0], bus.mem_wdata[31:16], bus.mem_wdata[7:2]};

  // Bus handshake state register
  always_ff @(posedge clk) begin
    if (!resetn) state <= BUS_IDLE;
    else         state <= state_next;
  end

  // Accept once per request; a master holding mem_valid is parked in HOLD until it lets go
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      BUS_IDLE: begin
        if (bus.mem_valid && in_window) begin
          accept     = 1'b1;
          state_next = BUS_ACK;
        end
      end
      BUS_ACK:  state_next = bus.mem_valid ? BUS_HOLD : BUS_IDLE;
      BUS_HOLD: if (!bus.mem_valid || !in_window) state_next = BUS_IDLE;
      default:  state_next = BUS_IDLE;
    endcase
  end

  assign bus.mem_ready = (state == BUS_ACK);

  assign do_pop   = accept && is_write && (word_off == OFF_POP);
  assign do_clear = accept && is_write && (word_off == OFF_CLEAR);
  assign ctrl_wr  = accept && is_write && (word_off == OFF_CTRL);
  assign clr_ovf  = do_clear && bus.mem_wdata[CLEAR_OVF];
  assign flush    = do_clear && bus.mem_wdata[CLEAR_FLUSH];

  rx_fifo_core #(
    .WIDTH (32 * DATA_WORDS),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (spi_rx_valid),
    .push_data (spi_rx_data),
    .pop       (do_pop),
    .flush     (flush),
    .head      (head),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .overrun   (overrun)
  );

  // Register read mux; write-only and empty data words read as zero
  always_comb begin
    rd_value = '0;
    case (word_off)
      OFF_STATUS: begin
        rd_value[STATUS_NOT_EMPTY]          = !empty;
        rd_value[STATUS_FULL]               = full;
        rd_value[STATUS_OVF]                = overflow;
        rd_value[STATUS_COUNT_LSB +: 8]     = count_ext;
      end
      OFF_CTRL: begin
        rd_value[CTRL_IRQ_EN]               = irq_en;
        rd_value[CTRL_OVF_IRQ_EN]           = ovf_irq_en;
        rd_value[CTRL_THR_LSB +: 8]         = threshold;
      end
      default: begin
        for (int i = 0; i < DATA_WORDS; i++) begin
          if (word_off == 8'(OFF_DATA + 4 * i) && !empty) begin
            rd_value = head[32*i +: 32];
          end
        end
      end
    endcase
  end

  // Read data is captured at the accept edge so it lines up with mem_ready
  always_ff @(posedge clk) begin
    if (!resetn)                 bus.mem_rdata <= '0;
    else if (accept && !is_write) bus.mem_rdata <= rd_value;
    else if (accept)             bus.mem_rdata <= '0;
  end

  // Control register; a zero threshold would make the level IRQ meaningless, so it becomes 1
  always_ff @(posedge clk) begin
    if (!resetn) begin
      irq_en     <= 1'b0;
      ovf_irq_en <= 1'b0;
      threshold  <= 8'd1;
    end else if (ctrl_wr) begin
      irq_en     <= bus.mem_wdata[CTRL_IRQ_EN];
      ovf_irq_en <= bus.mem_wdata[CTRL_OVF_IRQ_EN];
      threshold  <= (bus.mem_wdata[CTRL_THR_LSB +: 8] == 8'd0) ? 8'd1
                                                            : bus.mem_wdata[CTRL_THR_LSB +: 8];
    end
  end

  // Sticky overflow; a fresh drop in the same cycle as a clear keeps it set
  always_ff @(posedge clk) begin
    if (!resetn)      overflow <= 1'b0;
    else if (overrun) overflow <= 1'b1;
    else if (clr_ovf) overflow <= 1'b0;
  end

  // Registered level interrupt from the current fill level and overflow flag
  always_ff @(posedge clk) begin
    if (!resetn) irq_rx <= 1'b0;
    else         irq_rx <= (irq_en && (count_ext >= threshold)) || (ovf_irq_en && overflow);
  end

endmodule

// File: tb/tb_spi_rx_fifo_buffer.sv
// tb/tb_spi_rx_fifo_buffer.sv - vector table, corner sequences and random model check
module tb_spi_rx_fifo_buffer;
  localparam logic [31:0] BASE  = 32'h3000_0000;
  localparam int          DW    = 4;
  localparam int          DEPTH = 4;

  typedef enum int {V_PUSH, V_WR, V_RD, V_IDLE, V_IRQ} vop_t;
  typedef struct {
    vop_t        op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [127:0] blk;
    logic [31:0] exp;
  } vec_t;

  logic          clk = 1'b0;
  logic          resetn;
  logic [127:0]  spi_rx_data;
  logic          spi_rx_valid;
  logic          irq_rx;
  int            passed = 0;
  int            total  = 0;
  vec_t          vecs[$];

  logic [127:0]  mq[$];
  bit            movf;
  bit            men;
  bit            moen;
  int            mthr;

  spi_rx_fifo_buffer_if bus();

  spi_rx_fifo_buffer #(
    .BASE_ADDR  (BASE),
    .DATA_WORDS (DW),
    .DEPTH      (DEPTH)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .bus          (bus),
    .spi_rx_data  (spi_rx_data),
    .spi_rx_valid (spi_rx_valid),
    .irq_rx       (irq_rx)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [127:0] mk_blk(input logic [31:0] b);
    return {b + 32'd3, b + 32'd2, b + 32'd1, b};
  endfunction

  function automatic void add(input vop_t op, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [127:0] blk, input logic [31:0] exp);
    vecs.push_back('{op, addr, wdata, blk, exp});
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) @(negedge clk);
  endtask

  task automatic push_blk(input logic [127:0] b);
    spi_rx_valid = 1'b1;
    spi_rx_data  = b;
    @(negedge clk);
    spi_rx_valid = 1'b0;
  endtask

  task automatic bus_xfer(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb,
                          output logic [31:0] rdata);
    bit acked = 0;
    rdata         = '0;
    bus.mem_valid = 1'b1;
    bus.mem_addr  = addr;
    bus.mem_wdata = wdata;
    bus.mem_wstrb = wstrb;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus.mem_ready) begin
        acked = 1;
        rdata = bus.mem_rdata;
        break;
      end
    end
    bus.mem_valid = 1'b0;
    bus.mem_wstrb = 4'h0;
    chk($sformatf("ack addr %h", addr), {31'b0, acked}, 32'd1);
    @(negedge clk);
  endtask

  task automatic bus_wr(input logic [31:0] off, input logic [31:0] data);
    logic [31:0] dummy;
    bus_xfer(BASE + off, data, 4'hF, dummy);
  endtask

  task automatic bus_rd(input logic [31:0] off, output logic [31:0] data);
    bus_xfer(BASE + off, 32'h0, 4'h0, data);
  endtask

  task automatic rd_chk(input string name, input logic [31:0] off, input logic [31:0] exp);
    logic [31:0] d;
    bus_rd(off, d);
    chk(name, d, exp);
  endtask

  // Push and bus write launched in the same cycle
  task automatic push_with_write(input logic [127:0] b, input logic [31:0] off, input logic [31:0] data);
    spi_rx_valid  = 1'b1;
    spi_rx_data   = b;
    bus.mem_valid = 1'b1;
    bus.mem_addr  = BASE + off;
    bus.mem_wdata = data;
    bus.mem_wstrb = 4'hF;
    @(negedge clk);
    spi_rx_valid = 1'b0;
    chk("simul ack", {31'b0, bus.mem_ready}, 32'd1);
    bus.mem_valid = 1'b0;
    bus.mem_wstrb = 4'h0;
    @(negedge clk);
  endtask

  function automatic logic [31:0] model_status();
    int n = mq.size();
    return (32'(n) << 8) | (32'(movf) << 2) | (32'(n == DEPTH) << 1) | 32'(n != 0);
  endfunction

  function automatic logic model_irq();
    return (men && mq.size() >= mthr) || (moen && movf);
  endfunction

  initial begin
    logic [31:0] d;
    int          acks;

    resetn        = 1'b0;
    spi_rx_valid  = 1'b0;
    spi_rx_data   = '0;
    bus.mem_valid = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_wstrb = '0;

    // Reset state, then the three-block and overflow scenarios
    add(V_RD, 32'h00, 0, 0, 32'h0);
    add(V_RD, 32'h04, 0, 0, 32'h0100);
    add(V_RD, 32'h10, 0, 0, 32'h0);
    add(V_RD, 32'h08, 0, 0, 32'h0);
    add(V_IRQ, 0, 0, 0, 32'd0);
    add(V_PUSH, 0, 0, mk_blk(32'hA000_0000), 0);
    add(V_PUSH, 0, 0, mk_blk(32'hB000_0000), 0);
    add(V_PUSH, 0, 0, mk_blk(32'hC000_0000), 0);
    add(V_RD, 32'h00, 0, 0, 32'h0301);
    add(V_RD, 32'h10, 0, 0, 32'hA000_0000);
    add(V_RD, 32'h14, 0, 0, 32'hA000_0001);
    add(V_RD, 32'h18, 0, 0, 32'hA000_0002);
    add(V_RD, 32'h1C, 0, 0, 32'hA000_0003);
    add(V_WR, 32'h08, 0, 0, 0);
    add(V_RD, 32'h10, 0, 0, 32'hB000_0000);
    add(V_RD, 32'h00, 0, 0, 32'h0201);
    add(V_WR, 32'h0C, 32'h2, 0, 0);
    add(V_RD, 32'h00, 0, 0, 32'h0);
    for (int k = 1; k <= 5; k++) add(V_PUSH, 0, 0, mk_blk(32'(k) << 28), 0);
    add(V_RD, 32'h00, 0, 0, 32'h0407);
    add(V_RD, 32'h10, 0, 0, 32'h1000_0000);
    add(V_WR, 32'h0C, 32'h1, 0, 0);
    add(V_RD, 32'h00, 0, 0, 32'h0403);
    add(V_WR, 32'h08, 0, 0, 0);
    add(V_RD, 32'h10, 0, 0, 32'h2000_0000);
    add(V_WR, 32'h08, 0, 0, 0);
    add(V_RD, 32'h1C, 0, 0, 32'h3000_0003);
    add(V_WR, 32'h08, 0, 0, 0);
    add(V_RD, 32'h10, 0, 0, 32'h4000_0000);
    add(V_WR, 32'h08, 0, 0, 0);
    add(V_RD, 32'h00, 0, 0, 32'h0);
    add(V_RD, 32'h10, 0, 0, 32'h0);
    add(V_WR, 32'h08, 0, 0, 0);
    add(V_RD, 32'h00, 0, 0, 32'h0);
    add(V_WR, 32'h00, 32'hFFFF_FFFF, 0, 0);
    add(V_RD, 32'h00, 0, 0, 32'h0);
    add(V_WR, 32'h04, 32'h3, 0, 0);
    add(V_RD, 32'h04, 0, 0, 32'h0103);
    add(V_WR, 32'h04, 32'h0900, 0, 0);
    add(V_RD, 32'h04, 0, 0, 32'h0900);
    add(V_WR, 32'h04, 32'h0, 0, 0);
    add(V_RD, 32'h04, 0, 0, 32'h0100);
    // Level threshold interrupt
    add(V_WR, 32'h04, 32'h0201, 0, 0);
    add(V_PUSH, 0, 0, mk_blk(32'hD000_0000), 0);
    add(V_IDLE, 0, 0, 0, 0);
    add(V_IRQ, 0, 0, 0, 32'd0);
    add(V_PUSH, 0, 0, mk_blk(32'hE000_0000), 0);
    add(V_IRQ, 0, 0, 0, 32'd0);
    add(V_IDLE, 0, 0, 0, 0);
    add(V_IRQ, 0, 0, 0, 32'd1);
    add(V_WR, 32'h08, 0, 0, 0);
    add(V_IDLE, 0, 0, 0, 0);
    add(V_IRQ, 0, 0, 0, 32'd0);
    // Overflow interrupt
    add(V_WR, 32'h04, 32'h0102, 0, 0);
    add(V_IDLE, 0, 0, 0, 0);
    add(V_IRQ, 0, 0, 0, 32'd0);
    for (int k = 0; k < 4; k++) add(V_PUSH, 0, 0, mk_blk(32'h7000_0000 + 32'(k << 8)), 0);
    add(V_IDLE, 0, 0, 0, 0);
    add(V_IRQ, 0, 0, 0, 32'd1);
    add(V_RD, 32'h00, 0, 0, 32'h0407);
    add(V_WR, 32'h0C, 32'h3, 0, 0);
    add(V_IDLE, 0, 0, 0, 0);
    add(V_IRQ, 0, 0, 0, 32'd0);
    add(V_RD, 32'h00, 0, 0, 32'h0);
    add(V_WR, 32'h04, 32'h0100, 0, 0);

    idle(3);
    resetn = 1'b1;
    idle(1);

    for (int i = 0; i < vecs.size(); i++) begin
      case (vecs[i].op)
        V_PUSH: push_blk(vecs[i].blk);
        V_WR:   bus_wr(vecs[i].addr, vecs[i].wdata);
        V_RD: begin
          bus_rd(vecs[i].addr, d);
          chk($sformatf("vec%0d rd off %h", i, vecs[i].addr), d, vecs[i].exp);
        end
        V_IDLE: idle(1);
        V_IRQ:  chk($sformatf("vec%0d irq", i), {31'b0, irq_rx}, vecs[i].exp);
        default: ;
      endcase
    end

    // Push and pop together while full: no overflow, new block lands at the tail
    for (int k = 1; k <= 4; k++) push_blk(mk_blk(32'hF000_0000 + 32'(k << 20)));
    push_with_write(mk_blk(32'hF050_0000), 32'h08, 32'h0);
    rd_chk("full push+pop status", 32'h00, 32'h0403);
    rd_chk("full push+pop head", 32'h10, 32'hF020_0000);
    bus_wr(32'h08, 0);
    bus_wr(32'h08, 0);
    bus_wr(32'h08, 0);
    rd_chk("new tail reached", 32'h10, 32'hF050_0000);
    rd_chk("one left status", 32'h00, 32'h0101);
    bus_wr(32'h08, 0);

    // Held mem_valid on POP gives one ack and one pop
    push_blk(mk_blk(32'h1100_0000));
    push_blk(mk_blk(32'h2200_0000));
    acks = 0;
    bus.mem_valid = 1'b1;
    bus.mem_addr  = BASE + 32'h08;
    bus.mem_wstrb = 4'hF;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      acks += int'(bus.mem_ready);
    end
    bus.mem_valid = 1'b0;
    bus.mem_wstrb = 4'h0;
    idle(1);
    chk("held pop acks", 32'(acks), 32'd1);
    rd_chk("held pop status", 32'h00, 32'h0101);

    // Just past the window is never acknowledged
    acks = 0;
    bus.mem_valid = 1'b1;
    bus.mem_addr  = BASE + 32'h20;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      acks += int'(bus.mem_ready);
    end
    bus.mem_valid = 1'b0;
    idle(1);
    chk("out of window acks", 32'(acks), 32'd0);

    // Clear racing a new overflow, then flush racing a push while overflow is set
    for (int k = 0; k < 4; k++) push_blk(mk_blk(32'h5500_0000));
    rd_chk("refill status", 32'h00, 32'h0407);
    push_with_write(mk_blk(32'h5600_0000), 32'h0C, 32'h1);
    rd_chk("clear vs overflow", 32'h00, 32'h0407);
    push_with_write(mk_blk(32'h5700_0000), 32'h0C, 32'h2);
    rd_chk("flush vs push", 32'h00, 32'h0004);
    bus_wr(32'h0C, 32'h1);
    rd_chk("overflow cleared", 32'h00, 32'h0);

    // Reset with two entries and a read in flight
    push_blk(mk_blk(32'h8800_0000));
    push_blk(mk_blk(32'h9900_0000));
    bus_wr(32'h04, 32'h0203);
    idle(1);
    chk("irq before reset", {31'b0, irq_rx}, 32'd1);
    resetn        = 1'b0;
    bus.mem_valid = 1'b1;
    bus.mem_addr  = BASE;
    bus.mem_wstrb = 4'h0;
    @(negedge clk);
    chk("no ack in reset", {31'b0, bus.mem_ready}, 32'd0);
    chk("irq in reset", {31'b0, irq_rx}, 32'd0);
    resetn        = 1'b1;
    bus.mem_valid = 1'b0;
    idle(1);
    rd_chk("status after reset", 32'h00, 32'h0);
    rd_chk("ctrl after reset", 32'h04, 32'h0100);
    push_blk(mk_blk(32'hAB00_0000));
    push_blk(mk_blk(32'hAC00_0000));
    push_with_write(mk_blk(32'hAD00_0000), 32'h0C, 32'h2);
    rd_chk("flush with push", 32'h00, 32'h0);

    // Random traffic against a queue model
    mq.delete();
    movf = 0; men = 0; moen = 0; mthr = 1;
    for (int it = 0; it < 400; it++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r <= 3) begin
        logic [127:0] b;
        b = {$urandom, $urandom, $urandom, $urandom};
        push_blk(b);
        if (mq.size() < DEPTH) mq.push_back(b);
        else movf = 1;
      end else if (r <= 5) begin
        bus_wr(32'h08, $urandom);
        if (mq.size() > 0) void'(mq.pop_front());
      end else if (r == 6) begin
        rd_chk("rnd status", 32'h00, model_status());
      end else if (r == 7) begin
        int w;
        w = $urandom_range(0, DW - 1);
        rd_chk($sformatf("rnd data%0d", w), 32'h10 + 32'(4 * w),
               (mq.size() > 0) ? mq[0][32*w +: 32] : 32'h0);
      end else if (r == 8) begin
        logic [1:0] c;
        c = 2'($urandom_range(0, 3));
        bus_wr(32'h0C, {30'b0, c});
        if (c[1]) mq.delete();
        if (c[0]) movf = 0;
      end else begin
        int t;
        logic [1:0] e;
        t = $urandom_range(0, 6);
        e = 2'($urandom_range(0, 3));
        bus_wr(32'h04, (32'(t) << 8) | {30'b0, e});
        men  = e[0];
        moen = e[1];
        mthr = (t == 0) ? 1 : t;
      end
      idle(1);
      chk($sformatf("rnd irq it%0d", it), {31'b0, irq_rx}, {31'b0, model_irq()});
    end
    rd_chk("rnd final status", 32'h00, model_status());

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/spi_rx_fifo_buffer.md
Name: spi_rx_fifo_buffer

Overview:
- Memory-mapped receive buffer between the multi-lane SPI slave and the PicoRV32 native memory bus.
- Replaces the single-block latch with a DEPTH-entry FIFO of DATA_WORDS x 32-bit blocks.
- Adds explicit pop, flush, sticky overflow, and a level-threshold interrupt plus an overflow interrupt.
- The CPU drains blocks in arrival order without losing back-to-back SPI transfers.

Parameters:
BASE_ADDR, 32'h3000_0000, base of register window
DATA_WORDS, 4, 32-bit words per received block (legal 1..8)
DEPTH, 4, FIFO entries (power of 2, legal 2..128)

Ports:
clk  in  1  system clock
resetn  in  1  synchronous active-low reset
mem_valid  in  1  bus request
mem_ready  out  1  one-cycle acknowledge
mem_addr  in  32  byte address
mem_wdata  in  32  write data
mem_wstrb  in  4  write strobes; 0 = read
mem_rdata  out  32  read data, valid with mem_ready
spi_rx_data  in  32*DATA_WORDS  received block from SPI slave
spi_rx_valid  in  1  single-cycle push strobe
irq_rx  out  1  interrupt request, level

Behaviour:
- Single clock clk. Synchronous active-low reset resetn, sampled on rising edge.
- Reset values:
  - mem_ready=0, mem_rdata=0, irq_rx=0.
  - FIFO empty, count=0, overflow=0.
  - irq_en=0, ovf_irq_en=0, threshold=1.
- Window is BASE_ADDR .. BASE_ADDR+0x10+4*DATA_WORDS-1. Accesses outside the window are never acknowledged.
- Register map:
  - 0x00 STATUS (R): bit0 not_empty, bit1 full, bit2 overflow, [15:8] count. Other bits 0.
  - 0x04 CTRL (R/W): bit0 irq_en, bit1 ovf_irq_en, [15:8] threshold. A written threshold of 0 is stored as 1. Values above DEPTH are stored as written.
  - 0x08 POP (W): any write removes the head entry. Ignored when empty.
  - 0x0C CLEAR (W): bit0=1 clears overflow; bit1=1 flushes the FIFO (count=0). Both bits may be set together.
  - 0x10+4*i DATA_i (R), i<DATA_WORDS: word i of the head entry; word 0 = spi_rx_data[31:0]. Reads 0 when empty.
  - Writes to read-only registers are acked and ignored. Reads of write-only registers return 0.
- Bus handshake:
  - A transaction is accepted on the cycle with mem_valid && in-window && !mem_ready.
  - mem_ready is asserted for exactly one cycle on the next edge, with registered mem_rdata. Latency is 1 cycle; no back-to-back acks.
  - Write side effects occur once, at the accept edge. A held mem_valid never repeats a pop or clear.
  - Reads have no side effects.
- Push:
  - spi_rx_valid while not full writes the block at the tail; count+1 on the next edge.
  - spi_rx_valid while full drops the block and sets overflow (sticky).
- Simultaneous events:
  - Push and pop in the same cycle: both take effect, count unchanged. When full, the pop frees the slot, the push is stored, and no overflow is flagged.
  - Push and pop when empty: pop ignored, push stored.
  - Flush and push in the same cycle: flush wins, the block is discarded, overflow unchanged.
  - Overflow clear and a new overflow in the same cycle: overflow ends at 1.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. count is log2(DEPTH)+1 bits and is zero-extended into STATUS[15:8].
- irq_rx = (irq_en && count>=threshold) || (ovf_irq_en && overflow).
  - Registered, so it reflects state one cycle after any change.
  - Level output; it remains asserted until drained or cleared.
- Reset asserted mid-transaction: the FIFO empties, no ack is issued, and the bus master must reissue.

Decomposition:
- Package spi_rx_pkg:
  - Register offsets: STATUS, CTRL, POP, CLEAR, DATA_BASE.
  - STATUS bit indices, CTRL field positions and CLEAR bit indices.
- Sub-module rx_fifo_core:
  - Parametrised WIDTH/DEPTH synchronous FIFO: storage array, rd/wr pointers, count, full/empty.
  - Push/pop/flush inputs and a combinational head output.
- The top level holds the bus decode, control/status registers and IRQ logic.

Test Plan:
- Push 3 blocks A,B,C (DATA_WORDS=4) with no pops -> STATUS=0x0301. DATA_0..3 return A's words. Write POP -> DATA_0 returns B word0; STATUS=0x0201.
- Push 5 blocks into DEPTH=4 -> STATUS=0x0407 (count 4, full, overflow). Entries 1–4 intact, 5th lost. CLEAR=0x1 -> STATUS=0x0403.
- Fill to 4, then drive spi_rx_valid and an accepted POP in the same cycle -> count stays 4, overflow=0, and the new block becomes the tail after 3 more pops.
- CTRL=0x0201 (threshold 2, irq_en): one push -> irq_rx=0; second push -> irq_rx=1 one cycle later; POP -> irq_rx=0.
- Hold mem_valid high on POP for 4 cycles -> exactly one ack and one pop; count decreases by 1. Read at BASE_ADDR+0x20 (DATA_WORDS=4) -> no mem_ready.
- With 2 entries, assert resetn=0 for 1 cycle -> STATUS=0, CTRL=0x0100, irq_rx=0. CLEAR=0x2 with a simultaneous push -> count=0.
